// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage of the 16-bit CPU. Drives the
//               InstrMem address/write port, loads programs into InstrMem,
//               fetches sequentially into the IF/ID register, and handles
//               branch redirect, stall and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 16,
    parameter int                RESET_PC  = 0,
    parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [DATA_W-1:0] instr_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              valid_out,
    output logic [1:0]        state_out
);

    localparam logic [ADDR_W-1:0] C_RESET_PC  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] C_LOAD_BASE = '0;
    localparam logic [ADDR_W-1:0] C_PC_STEP   = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_instr;
    logic [ADDR_W-1:0]   r_instr_pc;
    logic                r_valid;

    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_is_halt;
    logic                w_load_write;

    // Next sequential address; natural overflow gives the wrap to 0.
    assign w_pc_inc     = r_pc + C_PC_STEP;
    assign w_is_halt    = (instr_in == HALT_WORD);
    // Write strobe is combinational so an async reset removes it at once.
    assign w_load_write = (r_state == S_LOAD) && load_valid;

    assign pc_out    = r_pc;
    assign mem_we    = w_load_write;
    assign mem_wdata = load_data;
    assign instr_out = r_instr;
    assign instr_pc  = r_instr_pc;
    assign valid_out = r_valid;
    assign state_out = r_state;

    // Fetch state machine, program counter and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= C_RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                // IDLE and HALT share entry rules; load_start outranks start.
                S_IDLE, S_HALT: begin
                    r_valid <= 1'b0;
                    if (load_start) begin
                        r_state <= S_LOAD;
                        r_pc    <= C_LOAD_BASE;
                    end else if (start) begin
                        r_state <= S_RUN;
                        r_pc    <= C_RESET_PC;
                    end
                end

                S_LOAD: begin
                    r_valid <= 1'b0;
                    if (load_valid) begin
                        r_pc <= w_pc_inc;
                    end
                    // A write in the same cycle as load_done still lands;
                    // only the address bookkeeping is replaced.
                    if (load_done) begin
                        r_state <= S_IDLE;
                        r_pc    <= C_RESET_PC;
                    end
                end

                S_RUN: begin
                    if (branch_taken) begin
                        // Word read this cycle is wrong-path: drop it.
                        r_pc    <= branch_target;
                        r_valid <= 1'b0;
                    end else if (!stall) begin
                        r_instr    <= instr_in;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        if (w_is_halt) begin
                            r_state <= S_HALT;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Acts as InstrMem, keeps a
//               behavioural reference model, and mixes directed scenarios with
//               randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int MEM_N = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, load_start, load_valid, load_done, stall, branch_taken;
    logic [15:0] load_data;
    logic [9:0]  branch_target;
    logic [15:0] instr_in;
    logic [9:0]  pc_out;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] instr_out;
    logic [9:0]  instr_pc;
    logic        valid_out;
    logic [1:0]  state_out;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    bit cmp_en   = 1'b0;

    // InstrMem stand-in: combinational read, clocked write.
    logic [15:0] imem [MEM_N];
    // Reference model state.
    logic [15:0] mmem [MEM_N];
    int          m_state, m_pc, m_ipc;
    logic [15:0] m_instr;
    logic        m_valid;

    fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_in(instr_in), .pc_out(pc_out), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .instr_out(instr_out), .instr_pc(instr_pc), .valid_out(valid_out),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    assign instr_in = imem[pc_out];

    // Memory write port driven by the DUT.
    always @(posedge clk) begin
        if (mem_we) imem[pc_out] <= mem_wdata;
    end

    // Behavioural reference: IDLE=0 LOAD=1 RUN=2 HALT=3.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0; m_pc <= 0; m_instr <= 16'h0; m_ipc <= 0; m_valid <= 1'b0;
        end else if (m_state == 0 || m_state == 3) begin
            m_valid <= 1'b0;
            if (load_start) begin m_state <= 1; m_pc <= 0; end
            else if (start) begin m_state <= 2; m_pc <= 0; end
        end else if (m_state == 1) begin
            if (load_valid) begin
                mmem[m_pc] <= load_data;
                m_pc <= (m_pc + 1) % MEM_N;
            end
            if (load_done) begin m_state <= 0; m_pc <= 0; end
        end else begin
            if (branch_taken) begin
                m_pc <= int'(branch_target); m_valid <= 1'b0;
            end else if (!stall) begin
                m_instr <= mmem[m_pc];
                m_ipc   <= m_pc;
                m_valid <= 1'b1;
                if (mmem[m_pc] == 16'hFFFF) m_state <= 3;
                else m_pc <= (m_pc + 1) % MEM_N;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc_out", 32'(pc_out), 32'(m_pc));
            chk("state_out", 32'(state_out), 32'(m_state));
            chk("valid_out", 32'(valid_out), 32'(m_valid));
            chk("instr_out", 32'(instr_out), 32'(m_instr));
            chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
            chk("mem_we", 32'(mem_we), 32'((m_state == 1) && load_valid && !rst));
            if (mem_we) begin
                chk("mem_wdata", 32'(mem_wdata), 32'(load_data));
                we_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == 16'hFFFF) w = 16'h0000;
        return w;
    endfunction

    initial begin
        logic [15:0] words [3];
        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'hABCD;
        rst = 1'b1; start = 0; load_start = 0; load_valid = 0; load_done = 0;
        stall = 0; branch_taken = 0; load_data = 16'h0; branch_target = 10'h0;
        for (int i = 0; i < MEM_N; i++) begin
            logic [15:0] w;
            w = rnd_word();
            if (i == 10)  w = 16'h00AA;
            if (i == 100) w = 16'hFFFF;
            imem[i] <= w;
            mmem[i] <= w;
        end
        #1 cmp_en = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_state", 32'(state_out), 0);
        chk("rst_we", 32'(mem_we), 0);
        rst = 1'b0;

        // Load three words
        load_start = 1; tick(); load_start = 0;
        chk("load_state", 32'(state_out), 1);
        we_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1; load_data = words[i];
            #1;
            chk("load_we", 32'(mem_we), 1);
            chk("load_pc", 32'(pc_out), 32'(i));
            tick();
        end
        load_valid = 0; load_done = 1; tick(); load_done = 0;
        chk("load_we_count", 32'(we_cnt), 3);
        chk("idle_state", 32'(state_out), 0);

        // Run the loaded words
        start = 1; tick(); start = 0;
        chk("run_state", 32'(state_out), 2);
        chk("run_pc0", 32'(pc_out), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fetch_instr", 32'(instr_out), 32'(words[i]));
            chk("fetch_ipc", 32'(instr_pc), 32'(i));
            chk("fetch_valid", 32'(valid_out), 1);
        end
        chk("pc_after3", 32'(pc_out), 3);

        // Branch to 10
        branch_taken = 1; branch_target = 10'd10; tick(); branch_taken = 0;
        chk("br_valid", 32'(valid_out), 0);
        chk("br_pc", 32'(pc_out), 10);
        tick();
        chk("br_instr", 32'(instr_out), 32'h00AA);
        chk("br_ipc", 32'(instr_pc), 10);

        // Stall, then stall together with branch
        stall = 1; tick(); tick(); tick();
        chk("stall_instr", 32'(instr_out), 32'h00AA);
        chk("stall_ipc", 32'(instr_pc), 10);
        chk("stall_valid", 32'(valid_out), 1);
        chk("stall_pc", 32'(pc_out), 11);
        branch_taken = 1; branch_target = 10'd5; tick();
        chk("stallbr_pc", 32'(pc_out), 5);
        stall = 0; branch_taken = 0;

        // Halt at 100
        branch_taken = 1; branch_target = 10'd100; tick(); branch_taken = 0;
        tick();
        chk("halt_instr", 32'(instr_out), 32'hFFFF);
        chk("halt_valid1", 32'(valid_out), 1);
        chk("halt_state", 32'(state_out), 3);
        tick(); tick();
        chk("halt_valid0", 32'(valid_out), 0);
        chk("halt_pc", 32'(pc_out), 100);
        start = 1; tick(); start = 0;
        chk("restart_pc", 32'(pc_out), 0);
        chk("restart_state", 32'(state_out), 2);

        // Sequential wrap in RUN
        branch_taken = 1; branch_target = 10'd1023; tick(); branch_taken = 0;
        tick();
        chk("wrap_run_pc", 32'(pc_out), 0);
        chk("wrap_run_ipc", 32'(instr_pc), 1023);

        // Halt, then reload the whole memory plus one word to wrap the load address
        branch_taken = 1; branch_target = 10'd100; tick(); branch_taken = 0;
        tick(); tick();
        load_start = 1; tick(); load_start = 0;
        for (int k = 0; k <= MEM_N; k++) begin
            load_valid = 1;
            load_data = (k == 100) ? 16'hFFFF : rnd_word();
            if (k >= MEM_N - 2) begin
                #1;
                chk("wrap_load_pc", 32'(pc_out), 32'(k % MEM_N));
                chk("wrap_load_we", 32'(mem_we), 1);
            end
            tick();
        end
        load_valid = 0; load_done = 1; tick(); load_done = 0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            stall         = ($urandom % 4) == 0;
            branch_taken  = ($urandom % 10) == 0;
            branch_target = 10'($urandom);
            start         = ($urandom % 16) == 0;
            load_start    = ($urandom % 40) == 0;
            load_valid    = ($urandom % 2) == 0;
            load_data     = (($urandom % 8) == 0) ? 16'hFFFF : rnd_word();
            load_done     = ($urandom % 30) == 0;
            tick();
        end
        stall = 0; branch_taken = 0; start = 0; load_start = 0;
        load_valid = 0; load_done = 0;

        // Reset in the middle of RUN
        rst = 1; tick(); rst = 0;
        start = 1; tick(); start = 0;
        tick(); tick(); tick();
        #2 rst = 1;
        #1;
        chk("rstrun_valid", 32'(valid_out), 0);
        chk("rstrun_state", 32'(state_out), 0);
        chk("rstrun_ipc", 32'(instr_pc), 0);
        tick(); rst = 0;

        // Reset in the middle of LOAD
        load_start = 1; tick(); load_start = 0;
        load_valid = 1; load_data = 16'h1111;
        #1;
        chk("rstload_we_before", 32'(mem_we), 1);
        #1 rst = 1;
        #1;
        chk("rstload_we", 32'(mem_we), 0);
        chk("rstload_state", 32'(state_out), 0);
        chk("rstload_pc", 32'(pc_out), 0);
        chk("rstload_valid", 32'(valid_out), 0);
        tick(); load_valid = 0; rst = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the 16-bit CPU. It sits directly upstream of InstrMem and drives its program_counter, en_write and data_in ports. It also captures InstrMem data_out into the IF/ID register for the decoder. It owns program loading into InstrMem, sequential fetch, branch redirect, stall and halt.

Parameters:
ADDR_W, 10, PC / InstrMem address width
DATA_W, 16, instruction width
RESET_PC, 0, fetch start address after start
HALT_WORD, 16'hFFFF, encoding that halts fetch

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse; begin fetching at RESET_PC (from IDLE or HALT)
load_start  input  1  pulse; enter program-load mode at address 0 (from IDLE or HALT)
load_valid  input  1  load_data holds a word to write this cycle (LOAD only)
load_data  input  DATA_W  program word to write
load_done  input  1  end load, return to IDLE
stall  input  1  hold fetch and IF/ID register
branch_taken  input  1  redirect fetch
branch_target  input  ADDR_W  redirect address
instr_in  input  DATA_W  InstrMem data_out; combinational read of pc_out in the same cycle
pc_out  output  ADDR_W  to InstrMem program_counter
mem_we  output  1  to InstrMem en_write
mem_wdata  output  DATA_W  to InstrMem data_in
instr_out  output  DATA_W  IF/ID instruction
instr_pc  output  ADDR_W  address instr_out was fetched from
valid_out  output  1  instr_out is a real instruction this cycle
state_out  output  2  IDLE=0, LOAD=1, RUN=2, HALT=3

Behaviour:
- Reset (async, immediate): state=IDLE, pc_out=RESET_PC, instr_out=0, instr_pc=0, valid_out=0. mem_we=0 during and after reset.
- mem_we = (state==LOAD) & load_valid. mem_wdata = load_data. Both are combinational. mem_wdata is a don't-care when mem_we=0.
- IDLE: valid_out<=0, pc held. load_start -> LOAD with pc<=0. Else start -> RUN with pc<=RESET_PC. If both are asserted, load_start wins.
- LOAD: on each load_valid cycle, the word is written at the current pc_out, then pc<=pc+1. pc wraps 2^ADDR_W-1 -> 0 silently. If load_done is asserted, any write in that same cycle still occurs; then state<=IDLE and pc<=RESET_PC. start, stall and branch are ignored in LOAD. valid_out stays 0.
- RUN, priority order per rising edge:
  1. branch_taken: pc<=branch_target, valid_out<=0 (wrong-path instr_in is discarded), instr_out/instr_pc unchanged. Overrides stall and halt detection.
  2. stall: pc, instr_out, instr_pc, valid_out all hold.
  3. Otherwise: instr_out<=instr_in, instr_pc<=pc_out, valid_out<=1.
     - If instr_in==HALT_WORD: state<=HALT and pc holds.
     - Else pc<=pc+1, wrapping to 0.
- Fetch latency: the instruction at address A appears on instr_out with valid_out=1 one edge after pc_out=A with no stall and no branch.
- HALT: the halt word is presented once with valid_out=1. On the next edge valid_out<=0, and it stays 0. pc holds. start -> RUN at RESET_PC. load_start -> LOAD at 0, with the same priority as in IDLE.
- start or load_start asserted in RUN or LOAD: ignored.
- Reset mid-LOAD: mem_we drops asynchronously, and no further writes occur.
- Reset mid-RUN: the pipeline register clears, and valid_out=0 immediately.

Test Plan:
- Load then run: load_start, write 16'h1234, 16'h5678, 16'hABCD to addresses 0..2 with load_valid. Check mem_we=1 on exactly 3 cycles with pc_out 0,1,2. Then load_done and start. Check instr_out sequence 1234/pc0, 5678/pc1, ABCD/pc2, each with valid_out=1.
- Branch: in RUN at pc=3, assert branch_taken with target 10, where mem[10]=16'h00AA. Check valid_out=0 for one cycle, pc_out=10, then instr_out=00AA and instr_pc=10.
- Stall and branch priority: assert stall for 3 cycles, then check instr_out, instr_pc, valid_out and pc_out are unchanged. Assert stall and branch_taken together with target 5 -> pc_out=5 on the next edge.
- Halt: place 16'hFFFF at address 100 and fetch it. Check instr_out=FFFF with valid_out=1 for one cycle, then valid_out=0, pc_out stays 100, state=HALT. Pulse start -> pc_out=RESET_PC, state=RUN.
- Wrap: load from pc 1022 with 3 words -> writes land at 1022, 1023, 0. In RUN from 1023 -> next pc_out=0.
- Reset mid-load: assert rst while load_valid=1 -> mem_we=0 the same cycle (before the clock edge), state=IDLE, pc_out=RESET_PC, valid_out=0.
